// File: rtl/branch_cond_resolver.sv
// ---------------------------------------------------------------------------
// branch_cond_resolver
//
// Resolves one branch per cycle for the fetch-stage PC mux. It selects either
// the stored NZVC flags or the flags the ALU is producing this cycle. It then
// evaluates the ARMv8 condition (B.cond) or the register-zero test (CBZ/CBNZ)
// and registers the taken/not-taken result. It also keeps saturating counters
// of resolved branches and taken branches.
//
// Parameters:
//   CNT_W          width of each saturating performance counter (>= 2)
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   in_valid       a branch is presented this cycle
//   br_kind        00 B, 01 B.cond, 10 CBZ, 11 CBNZ
//   cond           ARMv8 condition field (B.cond only)
//   reg_zero       tested register equals zero (CBZ/CBNZ)
//   flag_*         stored N/Z/V/C from the flag register
//   fwd_set        execute stage is writing flags this cycle
//   fwd_*          N/Z/V/C produced by the ALU this cycle
//   stall          hold all registered state
//   flush          kill the branch presented this cycle
//   out_valid      registered result valid
//   taken          registered resolved-taken
//   out_kind       registered br_kind of the resolved branch
//   branch_count   saturating count of accepted branches
//   taken_count    saturating count of accepted taken branches
// ---------------------------------------------------------------------------
module branch_cond_resolver #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       br_kind,
    input  logic [3:0]       cond,
    input  logic             reg_zero,
    input  logic             flag_neg,
    input  logic             flag_zero,
    input  logic             flag_of,
    input  logic             flag_co,
    input  logic             fwd_set,
    input  logic             fwd_neg,
    input  logic             fwd_zero,
    input  logic             fwd_of,
    input  logic             fwd_co,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic             taken,
    output logic [1:0]       out_kind,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    logic             w_n;
    logic             w_z;
    logic             w_v;
    logic             w_c;
    logic             w_cond_true;
    logic             w_resolved;
    logic             w_accept;

    logic             r_out_valid;
    logic             r_taken;
    logic [1:0]       r_out_kind;
    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_taken_count;

    // The forwarded flags are what the flag register captures on this edge,
    // so selecting them here removes the stall a flag-setting predecessor
    // would otherwise need.
    always_comb begin
        w_n = fwd_set ? fwd_neg  : flag_neg;
        w_z = fwd_set ? fwd_zero : flag_zero;
        w_v = fwd_set ? fwd_of   : flag_of;
        w_c = fwd_set ? fwd_co   : flag_co;
    end

    always_comb begin
        w_cond_true = 1'b1;
        case (cond)
            4'b0000: w_cond_true =  w_z;                        // EQ
            4'b0001: w_cond_true = ~w_z;                        // NE
            4'b0010: w_cond_true =  w_c;                        // HS
            4'b0011: w_cond_true = ~w_c;                        // LO
            4'b0100: w_cond_true =  w_n;                        // MI
            4'b0101: w_cond_true = ~w_n;                        // PL
            4'b0110: w_cond_true =  w_v;                        // VS
            4'b0111: w_cond_true = ~w_v;                        // VC
            4'b1000: w_cond_true =  (w_c & ~w_z);               // HI
            4'b1001: w_cond_true = ~(w_c & ~w_z);               // LS
            4'b1010: w_cond_true =  (w_n ~^ w_v);               // GE
            4'b1011: w_cond_true =  (w_n ^ w_v);                // LT
            4'b1100: w_cond_true =  (~w_z & (w_n ~^ w_v));      // GT
            4'b1101: w_cond_true = ~(~w_z & (w_n ~^ w_v));      // LE
            default: w_cond_true = 1'b1;                        // AL, NV
        endcase
    end

    always_comb begin
        w_resolved = 1'b1;
        case (br_kind)
            2'b00:   w_resolved = 1'b1;
            2'b01:   w_resolved = w_cond_true;
            2'b10:   w_resolved = reg_zero;
            default: w_resolved = ~reg_zero;
        endcase
    end

    assign w_accept = in_valid & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_taken        <= 1'b0;
            r_out_kind     <= '0;
            r_branch_count <= '0;
            r_taken_count  <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_taken     <= 1'b0;
        end else if (!stall) begin
            r_out_valid <= in_valid;
            r_taken     <= in_valid & w_resolved;
            r_out_kind  <= br_kind;
            if (w_accept) begin
                if (r_branch_count != '1)
                    r_branch_count <= r_branch_count + CNT_W'(1);
                if (w_resolved && (r_taken_count != '1))
                    r_taken_count <= r_taken_count + CNT_W'(1);
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign taken        = r_taken;
    assign out_kind     = r_out_kind;
    assign branch_count = r_branch_count;
    assign taken_count  = r_taken_count;

endmodule

// File: tb/tb_branch_cond_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_cond_resolver
//
// Drives two instances that share the same inputs: one with 16-bit counters
// and one with 2-bit counters, so the 2-bit one exercises saturation. Each
// cycle the outputs are compared against a behavioural model that holds the
// expected registered state. Directed table vectors, hand-written
// stall/flush/saturation sequences and a randomized phase are included.
// ---------------------------------------------------------------------------
module tb_branch_cond_resolver;

    logic        clk = 1'b0;
    logic        reset, in_valid, reg_zero, stall, flush;
    logic [1:0]  br_kind;
    logic [3:0]  cond;
    logic        flag_neg, flag_zero, flag_of, flag_co;
    logic        fwd_set, fwd_neg, fwd_zero, fwd_of, fwd_co;

    logic        ov16, tk16, ov2, tk2;
    logic [1:0]  ok16, ok2;
    logic [15:0] bc16, tc16;
    logic [1:0]  bc2, tc2;

    int n_cmp = 0;
    int n_err = 0;

    // expected registered state
    bit      m_valid, m_taken;
    int      m_kind;
    int      m_bc16, m_tc16, m_bc2, m_tc2;

    always #5 clk = ~clk;

    branch_cond_resolver #(.CNT_W(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .br_kind(br_kind),
        .cond(cond), .reg_zero(reg_zero), .flag_neg(flag_neg),
        .flag_zero(flag_zero), .flag_of(flag_of), .flag_co(flag_co),
        .fwd_set(fwd_set), .fwd_neg(fwd_neg), .fwd_zero(fwd_zero),
        .fwd_of(fwd_of), .fwd_co(fwd_co), .stall(stall), .flush(flush),
        .out_valid(ov16), .taken(tk16), .out_kind(ok16),
        .branch_count(bc16), .taken_count(tc16)
    );

    branch_cond_resolver #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .br_kind(br_kind),
        .cond(cond), .reg_zero(reg_zero), .flag_neg(flag_neg),
        .flag_zero(flag_zero), .flag_of(flag_of), .flag_co(flag_co),
        .fwd_set(fwd_set), .fwd_neg(fwd_neg), .fwd_zero(fwd_zero),
        .fwd_of(fwd_of), .fwd_co(fwd_co), .stall(stall), .flush(flush),
        .out_valid(ov2), .taken(tk2), .out_kind(ok2),
        .branch_count(bc2), .taken_count(tc2)
    );

    typedef struct {
        int kind; int cnd; bit rz;
        bit n, z, v, c;
        bit fs, fn, fz, fv, fc;
        bit exp;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Condition evaluation from the ARMv8 rules: pairs of conditions share a
    // base test and the odd member is its negation; 1111 is also "always".
    function automatic bit ref_resolve(input int kind, input int cnd, input bit rz,
                                       input bit fs, input bit sn, input bit sz,
                                       input bit sv, input bit sc, input bit fn,
                                       input bit fz, input bit fv, input bit fc);
        bit n, z, v, c, base;
        n = fs ? fn : sn;  z = fs ? fz : sz;
        v = fs ? fv : sv;  c = fs ? fc : sc;
        if (kind == 0) return 1'b1;
        if (kind == 2) return rz;
        if (kind == 3) return !rz;
        case (cnd / 2)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cnd == 15) return 1'b1;
        return (cnd % 2 == 1) ? !base : base;
    endfunction

    function automatic int sat_inc(input int x, input int w);
        int lim = (1 << w) - 1;
        return (x + 1 > lim) ? lim : x + 1;
    endfunction

    // One clock: model next state from the current inputs, advance, compare.
    task automatic tick();
        bit r;
        bit acc;
        r = ref_resolve(int'(br_kind), int'(cond), reg_zero, fwd_set, flag_neg,
                        flag_zero, flag_of, flag_co, fwd_neg, fwd_zero, fwd_of, fwd_co);
        acc = in_valid && !stall && !flush;
        if (reset) begin
            m_valid = 0; m_taken = 0; m_kind = 0;
            m_bc16 = 0; m_tc16 = 0; m_bc2 = 0; m_tc2 = 0;
        end else if (flush) begin
            m_valid = 0; m_taken = 0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_taken = in_valid && r;
            m_kind  = int'(br_kind);
        end
        if (!reset && acc) begin
            m_bc16 = sat_inc(m_bc16, 16);
            m_bc2  = sat_inc(m_bc2, 2);
            if (r) begin
                m_tc16 = sat_inc(m_tc16, 16);
                m_tc2  = sat_inc(m_tc2, 2);
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid",  int'(ov16), int'(m_valid));
        chk("taken",      int'(tk16), int'(m_taken));
        chk("out_kind",   int'(ok16), m_kind);
        chk("branch_cnt16", int'(bc16), m_bc16);
        chk("taken_cnt16",  int'(tc16), m_tc16);
        chk("branch_cnt2",  int'(bc2), m_bc2);
        chk("taken_cnt2",   int'(tc2), m_tc2);
        chk("out_valid2", int'(ov2), int'(m_valid));
        chk("taken2",     int'(tk2), int'(m_taken));
        chk("inv_tc_le_bc", int'(tc16 <= bc16), 1);
        chk("inv_taken_valid", int'(!tk16 || ov16), 1);
    endtask

    task automatic drive_vec(input vec_t t);
        br_kind = 2'(t.kind); cond = 4'(t.cnd); reg_zero = t.rz;
        flag_neg = t.n; flag_zero = t.z; flag_of = t.v; flag_co = t.c;
        fwd_set = t.fs; fwd_neg = t.fn; fwd_zero = t.fz; fwd_of = t.fv; fwd_co = t.fc;
    endtask

    task automatic randomize_inputs();
        in_valid = 1'($urandom); br_kind = 2'($urandom); cond = 4'($urandom);
        reg_zero = 1'($urandom);
        flag_neg = 1'($urandom); flag_zero = 1'($urandom);
        flag_of = 1'($urandom); flag_co = 1'($urandom);
        fwd_set = 1'($urandom); fwd_neg = 1'($urandom); fwd_zero = 1'($urandom);
        fwd_of = 1'($urandom); fwd_co = 1'($urandom);
    endtask

    initial begin
        logic [15:0] sweep_exp;
        int          sat_exp[5];
        int          hold_bc, hold_tc;
        vec_t        v;

        sweep_exp = 16'b1110_0110_1010_0101;   // bit i = expected taken for cond i
        sat_exp   = '{1, 2, 3, 3, 3};

        for (int i = 0; i < 16; i++)
            tv.push_back('{kind:1, cnd:i, rz:0, n:0, z:1, v:0, c:1,
                           fs:0, fn:1, fz:0, fv:1, fc:0, exp:sweep_exp[i]});
        // forwarding
        tv.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1});
        tv.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0});
        tv.push_back('{1, 12, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1});
        tv.push_back('{1, 13, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0});
        // CBZ / CBNZ / B, including conflicting flags
        tv.push_back('{2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        tv.push_back('{2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        tv.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1});
        tv.push_back('{2, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1});
        tv.push_back('{3, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0});

        // reset with random inputs, then idle
        reset = 1; stall = 0; flush = 0;
        randomize_inputs(); stall = 1'($urandom); flush = 1'($urandom);
        m_valid = 1; m_taken = 1; m_kind = 3;   // overwritten by the reset tick
        tick();
        randomize_inputs(); stall = 1'($urandom); flush = 1'($urandom);
        tick();
        reset = 0; in_valid = 0; stall = 0; flush = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_bc", int'(bc16), 0);

        // directed table
        in_valid = 1;
        foreach (tv[i]) begin
            drive_vec(tv[i]);
            tick();
            chk($sformatf("vec%0d_taken", i), int'(tk16), int'(tv[i].exp));
            if (i == 15) begin
                chk("sweep_bc", int'(bc16), 16);
                chk("sweep_tc", int'(tc16), 9);
            end
        end

        // taken branch, then 3 stalled cycles with another branch presented
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        drive_vec(v); tick();
        hold_bc = int'(bc16); hold_tc = int'(tc16);
        stall = 1;
        v = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive_vec(v);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_taken", int'(tk16), 1);
            chk("stall_kind", int'(ok16), 0);
            chk("stall_bc", int'(bc16), hold_bc);
            chk("stall_tc", int'(tc16), hold_tc);
        end
        flush = 1;
        tick();
        chk("sf_valid", int'(ov16), 0);
        chk("sf_taken", int'(tk16), 0);
        chk("sf_bc", int'(bc16), hold_bc);
        stall = 0; flush = 0;

        // saturation on the 2-bit instance
        reset = 1; tick(); reset = 0;
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        drive_vec(v); in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_bc2", int'(bc2), sat_exp[i]);
            chk("sat_tc2", int'(tc2), sat_exp[i]);
        end
        reset = 1; tick(); reset = 0;
        chk("rst_bc2", int'(bc2), 0);
        chk("rst_tc2", int'(tc2), 0);
        chk("rst_bc16", int'(bc16), 0);

        // randomized phase
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
